accel_io_master: RTL and testbench
==================================

# accel_io_master

Core-side initiator for the accelerator IO port: accepts single 32-bit MMIO requests from a RISC-V core's data path over a valid/ready handshake, drives the `io_*` request bus of an accelerator wrapper, and returns read data to the core. Writes are posted. Reads are tracked to completion with a bounded timeout, so a missing or broken accelerator cannot hang the core. It sits between the core's IO decode and the accelerator wrapper inside each processing-core tile.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: maximum number of cycles after the read `io_en` pulse during which `io_rd_valid` is accepted; must be ≥ 1.
- `TIMEOUT_WIDTH`, `$clog2(TIMEOUT_CYCLES+1)`: width of the wait counter.
- `ERR_DATA`, 32'hDEADBEEF: read data returned on timeout.
- `CNT_WIDTH`, 16: width of the timeout event counter.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, synchronous and active-high.
- `core_req_valid`, in, 1: request present.
- `core_req_ready`, out, 1: block can accept a request.
- `core_req_wen`, in, 1: 1 = write, 0 = read.
- `core_req_strb`, in, 4: byte strobes.
- `core_req_addr`, in, 22: IO address.
- `core_req_wr_data`, in, 32: write data.
- `core_resp_valid`, out, 1: one-cycle read-response pulse.
- `core_resp_data`, out, 32: read data, valid with `core_resp_valid`.
- `core_resp_err`, out, 1: response is a timeout, valid with `core_resp_valid`.
- `io_en`, out, 1: one-cycle access strobe to the accelerator.
- `io_wen`, out, 1: write qualifier for `io_en`.
- `io_strb`, out, 4: byte strobes.
- `io_addr`, out, 22: address.
- `io_wr_data`, out, 32: write data.
- `io_rd_data`, in, 32: accelerator read data.
- `io_rd_valid`, in, 1: accelerator read-data strobe.
- `timeout_count`, out, `CNT_WIDTH`: saturating count of read timeouts.

## Operation
- States: IDLE, ISSUE, WAIT. Reset enters IDLE.
- `core_req_ready` is 1 only when the state is IDLE and `rst` is 0. It is derived combinationally from the state.
- Accept means `core_req_valid && core_req_ready`. Request fields are registered onto `io_wen`, `io_strb`, `io_addr` and `io_wr_data` on accept.
- Write accept: `io_en` = 1 and `io_wen` = 1 in the next cycle, for exactly one cycle. The state stays IDLE. No core response is generated. Back-to-back writes are accepted one per cycle.
- Read accept: the state moves to ISSUE. In ISSUE, `io_en` = 1 and `io_wen` = 0 for one cycle, the wait counter is cleared to 0, and the state moves to WAIT.
- WAIT: the counter increments every cycle and saturates at `TIMEOUT_CYCLES`.
  - `io_rd_valid` = 1: capture `io_rd_data`, pulse the response with err = 0, and return to IDLE.
  - Counter == `TIMEOUT_CYCLES` and no `io_rd_valid`: pulse the response with data = `ERR_DATA` and err = 1, increment `timeout_count` (it saturates at all-ones, no wrap), and return to IDLE.
  - `io_rd_valid` in the same cycle as the timeout: the valid data wins, and no timeout is counted.
- `io_rd_valid` in IDLE or ISSUE is ignored. This covers late responses after a timeout and stray pulses.
- `io_wen`, `io_strb`, `io_addr` and `io_wr_data` hold their last values between accesses. They are meaningful only while `io_en` = 1.
- `rst` during ISSUE or WAIT abandons the read:
  - no response is produced;
  - the state returns to IDLE;
  - all outputs reset;
  - a subsequent `io_rd_valid` is ignored.

## Timing
- Reset values are 0 for `io_en`, `io_wen`, `io_strb`, `io_addr`, `io_wr_data`, `core_resp_valid`, `core_resp_data`, `core_resp_err` and `timeout_count`. `core_req_ready` is 0 while `rst` = 1 and 1 from the first cycle after reset.
- Write: accept at cycle A gives `io_en` at A+1.
- Read: accept at A, `io_en` at A+1 (ISSUE), first WAIT cycle at A+2.
  - `io_rd_valid` at cycle V (V ≥ A+2) gives `core_resp_valid` at V+1, with `core_req_ready` = 1 at V+1.
  - No valid arrives by A+1+`TIMEOUT_CYCLES`: error response at A+2+`TIMEOUT_CYCLES`.
- Minimum read round trip with a same-cycle-registered accelerator (valid at A+2) is 3 cycles from accept to response.
- `core_resp_valid` is a single-cycle pulse. The core must sink it; there is no backpressure.

## Test plan
- Reset then a write (addr 22'h000010, data 32'h12345678, strb 4'hF) accepted at cycle 0 -> `io_en` = 1 and `io_wen` = 1 at cycle 1 with those values, no `core_resp_valid`, `core_req_ready` stays 1.
- Four back-to-back writes -> four consecutive `io_en` pulses, each carrying its own addr and data.
- Read accepted at cycle 0 and accelerator returns 32'hCAFEF00D at cycle 5 -> `core_resp_valid` = 1 at cycle 6 with that data and err = 0, `core_req_ready` = 0 during cycles 1–5.
- `TIMEOUT_CYCLES` = 8, read with no response -> response at cycle 10 with 32'hDEADBEEF and err = 1, `timeout_count` = 1; a late `io_rd_valid` at cycle 12 produces no response.
- `io_rd_valid` in the exact timeout cycle (cycle 9 with `TIMEOUT_CYCLES` = 8) -> real data returned, err = 0, `timeout_count` unchanged.
- `rst` asserted at cycle 3 of a pending read, then `io_rd_valid` at cycle 6 -> no `core_resp_valid` at any point, all outputs 0 during reset, `core_req_ready` = 1 after release.

Source files
------------

// File: rtl/accel_io_master.sv
// Core-side MMIO initiator for the accelerator IO port: posted writes, and reads
// tracked to completion with a bounded timeout so a dead accelerator cannot hang the core.
module accel_io_master #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          TIMEOUT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1),
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF,
  parameter int          CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 core_req_valid,
  output logic                 core_req_ready,
  input  logic                 core_req_wen,
  input  logic [3:0]           core_req_strb,
  input  logic [21:0]          core_req_addr,
  input  logic [31:0]          core_req_wr_data,
  output logic                 core_resp_valid,
  output logic [31:0]          core_resp_data,
  output logic                 core_resp_err,
  output logic                 io_en,
  output logic                 io_wen,
  output logic [3:0]           io_strb,
  output logic [21:0]          io_addr,
  output logic [31:0]          io_wr_data,
  input  logic [31:0]          io_rd_data,
  input  logic                 io_rd_valid,
  output logic [CNT_WIDTH-1:0] timeout_count
);

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_MAX = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Handshake: a request transfers on a cycle where core_req_valid and
  // core_req_ready are both 1; ready depends only on state and rst.
  state_t                   state;
  state_t                   state_nxt;
  logic [TIMEOUT_WIDTH-1:0] wait_cnt;
  logic                     accept;
  logic                     rd_done;
  logic                     timeout_hit;

  assign core_req_ready = (state == IDLE) && !rst;
  assign accept         = core_req_valid && core_req_ready;
  assign rd_done        = (state == WAIT) && io_rd_valid;
  // Valid data in the final window cycle beats the timeout.
  assign timeout_hit    = (state == WAIT) && !io_rd_valid && (wait_cnt == TIMEOUT_MAX);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !core_req_wen) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (rd_done || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      io_en           <= 1'b0;
      io_wen          <= 1'b0;
      io_strb         <= '0;
      io_addr         <= '0;
      io_wr_data      <= '0;
      core_resp_valid <= 1'b0;
      core_resp_data  <= '0;
      core_resp_err   <= 1'b0;
      timeout_count   <= '0;
    end else begin
      state           <= state_nxt;
      io_en           <= accept;
      core_resp_valid <= rd_done || timeout_hit;

      if (accept) begin
        io_wen     <= core_req_wen;
        io_strb    <= core_req_strb;
        io_addr    <= core_req_addr;
        io_wr_data <= core_req_wr_data;
      end

      // Counter reads 0 in ISSUE, so it reaches TIMEOUT_MAX on the last WAIT cycle of the window.
      if (accept)
        wait_cnt <= '0;
      else if (state != IDLE && wait_cnt != TIMEOUT_MAX)
        wait_cnt <= wait_cnt + 1'b1;

      if (rd_done) begin
        core_resp_data <= io_rd_data;
        core_resp_err  <= 1'b0;
      end else if (timeout_hit) begin
        core_resp_data <= ERR_DATA;
        core_resp_err  <= 1'b1;
        if (timeout_count != '1)
          timeout_count <= timeout_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_accel_io_master.sv
// Directed bench for accel_io_master: write vector table plus hand-written
// read, timeout, same-cycle race and reset-abort sequences.
module tb_accel_io_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req_valid;
  logic        core_req_ready;
  logic        core_req_wen;
  logic [3:0]  core_req_strb;
  logic [21:0] core_req_addr;
  logic [31:0] core_req_wr_data;
  logic        core_resp_valid;
  logic [31:0] core_resp_data;
  logic        core_resp_err;
  logic        io_en;
  logic        io_wen;
  logic [3:0]  io_strb;
  logic [21:0] io_addr;
  logic [31:0] io_wr_data;
  logic [31:0] io_rd_data;
  logic        io_rd_valid;
  logic [15:0] timeout_count;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [21:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        exp_en;
    logic        exp_wen;
  } wr_vec_t;

  wr_vec_t vecs[4];

  accel_io_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .core_req_valid   (core_req_valid),
    .core_req_ready   (core_req_ready),
    .core_req_wen     (core_req_wen),
    .core_req_strb    (core_req_strb),
    .core_req_addr    (core_req_addr),
    .core_req_wr_data (core_req_wr_data),
    .core_resp_valid  (core_resp_valid),
    .core_resp_data   (core_resp_data),
    .core_resp_err    (core_resp_err),
    .io_en            (io_en),
    .io_wen           (io_wen),
    .io_strb          (io_strb),
    .io_addr          (io_addr),
    .io_wr_data       (io_wr_data),
    .io_rd_data       (io_rd_data),
    .io_rd_valid      (io_rd_valid),
    .timeout_count    (timeout_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_req(input logic wen, input logic [21:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
    core_req_valid   = 1'b1;
    core_req_wen     = wen;
    core_req_addr    = addr;
    core_req_wr_data = data;
    core_req_strb    = strb;
  endtask

  task automatic idle_req();
    core_req_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_io_en"},   32'(io_en), 32'd0);
    chk({tag, "_io_wen"},  32'(io_wen), 32'd0);
    chk({tag, "_io_strb"}, 32'(io_strb), 32'd0);
    chk({tag, "_io_addr"}, 32'(io_addr), 32'd0);
    chk({tag, "_io_wdat"}, io_wr_data, 32'd0);
    chk({tag, "_rvalid"},  32'(core_resp_valid), 32'd0);
    chk({tag, "_rdata"},   core_resp_data, 32'd0);
    chk({tag, "_rerr"},    32'(core_resp_err), 32'd0);
    chk({tag, "_tocnt"},   32'(timeout_count), 32'd0);
    chk({tag, "_ready"},   32'(core_req_ready), 32'd0);
  endtask

  initial begin
    vecs[0] = '{22'h000020, 32'hA5A5A5A5, 4'h1, 1'b1, 1'b1};
    vecs[1] = '{22'h3FFFFC, 32'h00000001, 4'h3, 1'b1, 1'b1};
    vecs[2] = '{22'h000104, 32'hFFFFFFFF, 4'hC, 1'b1, 1'b1};
    vecs[3] = '{22'h155554, 32'h0BADF00D, 4'hF, 1'b1, 1'b1};

    rst = 1'b1;
    core_req_valid = 1'b0;
    core_req_wen = 1'b0;
    core_req_strb = '0;
    core_req_addr = '0;
    core_req_wr_data = '0;
    io_rd_data = '0;
    io_rd_valid = 1'b0;
    step(); step();
    chk_all_zero("reset");
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 32'(core_req_ready), 32'd1);

    // single write, accept at cycle 0
    drive_req(1'b1, 22'h000010, 32'h12345678, 4'hF);
    step();
    idle_req();
    chk("wr_io_en",   32'(io_en), 32'd1);
    chk("wr_io_wen",  32'(io_wen), 32'd1);
    chk("wr_io_addr", 32'(io_addr), 32'h10);
    chk("wr_io_data", io_wr_data, 32'h12345678);
    chk("wr_io_strb", 32'(io_strb), 32'hF);
    chk("wr_no_resp", 32'(core_resp_valid), 32'd0);
    chk("wr_ready",   32'(core_req_ready), 32'd1);
    step();
    chk("wr_en_drop", 32'(io_en), 32'd0);
    chk("wr_no_resp2", 32'(core_resp_valid), 32'd0);

    // back-to-back writes from the table
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b1, vecs[i].addr, vecs[i].data, vecs[i].strb);
      chk($sformatf("b2b_ready_%0d", i), 32'(core_req_ready), 32'd1);
      step();
      chk($sformatf("b2b_en_%0d", i),   32'(io_en), 32'(vecs[i].exp_en));
      chk($sformatf("b2b_wen_%0d", i),  32'(io_wen), 32'(vecs[i].exp_wen));
      chk($sformatf("b2b_addr_%0d", i), 32'(io_addr), 32'(vecs[i].addr));
      chk($sformatf("b2b_data_%0d", i), io_wr_data, vecs[i].data);
      chk($sformatf("b2b_strb_%0d", i), 32'(io_strb), 32'(vecs[i].strb));
      chk($sformatf("b2b_resp_%0d", i), 32'(core_resp_valid), 32'd0);
    end
    idle_req();
    step();
    chk("b2b_en_end", 32'(io_en), 32'd0);

    // read, accelerator answers at cycle 5
    drive_req(1'b0, 22'h000040, 32'h0, 4'hF);
    step();
    idle_req();
    chk("rd_issue_en",   32'(io_en), 32'd1);
    chk("rd_issue_wen",  32'(io_wen), 32'd0);
    chk("rd_issue_addr", 32'(io_addr), 32'h40);
    chk("rd_ready_c1",   32'(core_req_ready), 32'd0);
    for (int c = 2; c <= 5; c++) begin
      step();
      chk($sformatf("rd_ready_c%0d", c), 32'(core_req_ready), 32'd0);
      chk($sformatf("rd_noresp_c%0d", c), 32'(core_resp_valid), 32'd0);
      chk($sformatf("rd_en_c%0d", c), 32'(io_en), 32'd0);
    end
    io_rd_valid = 1'b1;
    io_rd_data  = 32'hCAFEF00D;
    step();
    io_rd_valid = 1'b0;
    chk("rd_resp_valid", 32'(core_resp_valid), 32'd1);
    chk("rd_resp_data",  core_resp_data, 32'hCAFEF00D);
    chk("rd_resp_err",   32'(core_resp_err), 32'd0);
    chk("rd_ready_c6",   32'(core_req_ready), 32'd1);
    step();
    chk("rd_resp_pulse", 32'(core_resp_valid), 32'd0);

    // timeout with TIMEOUT_CYCLES = 8
    drive_req(1'b0, 22'h000080, 32'h0, 4'hF);
    step();
    idle_req();
    for (int c = 2; c <= 9; c++) begin
      step();
      chk($sformatf("to_noresp_c%0d", c), 32'(core_resp_valid), 32'd0);
    end
    step();
    chk("to_resp_valid", 32'(core_resp_valid), 32'd1);
    chk("to_resp_data",  core_resp_data, 32'hDEADBEEF);
    chk("to_resp_err",   32'(core_resp_err), 32'd1);
    chk("to_count",      32'(timeout_count), 32'd1);
    chk("to_ready",      32'(core_req_ready), 32'd1);
    step();
    io_rd_valid = 1'b1;
    io_rd_data  = 32'h11111111;
    step();
    io_rd_valid = 1'b0;
    chk("late_valid_ignored", 32'(core_resp_valid), 32'd0);
    step();
    chk("late_valid_ignored2", 32'(core_resp_valid), 32'd0);
    chk("late_ready", 32'(core_req_ready), 32'd1);

    // valid in the exact timeout cycle (cycle 9)
    drive_req(1'b0, 22'h0000C0, 32'h0, 4'hF);
    step();
    idle_req();
    for (int c = 2; c <= 9; c++) begin
      step();
      chk($sformatf("race_noresp_c%0d", c), 32'(core_resp_valid), 32'd0);
    end
    io_rd_valid = 1'b1;
    io_rd_data  = 32'h55AA1234;
    step();
    io_rd_valid = 1'b0;
    chk("race_resp_valid", 32'(core_resp_valid), 32'd1);
    chk("race_resp_data",  core_resp_data, 32'h55AA1234);
    chk("race_resp_err",   32'(core_resp_err), 32'd0);
    chk("race_count",      32'(timeout_count), 32'd1);
    step();

    // reset abandons a pending read
    drive_req(1'b0, 22'h000100, 32'h0, 4'hF);
    step();
    idle_req();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("rstab_ready_in_rst", 32'(core_req_ready), 32'd0);
    step();
    chk_all_zero("rstab");
    rst = 1'b0;
    step();
    chk("rstab_ready_after", 32'(core_req_ready), 32'd1);
    io_rd_valid = 1'b1;
    io_rd_data  = 32'h77777777;
    step();
    io_rd_valid = 1'b0;
    for (int c = 7; c <= 9; c++) begin
      chk($sformatf("rstab_noresp_c%0d", c), 32'(core_resp_valid), 32'd0);
      chk($sformatf("rstab_ready_c%0d", c), 32'(core_req_ready), 32'd1);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
